// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM encoding and op-decode helpers for the multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // Ops 0..3 are the iterative MULT/MULTU/DIV/DIVU group.
  function automatic logic md_is_arith(input logic [OP_W-1:0] op);
    return ~op[2];
  endfunction

  function automatic logic md_is_signed(input logic [OP_W-1:0] op);
    return ~op[2] & ~op[0];
  endfunction

  function automatic logic md_is_div(input logic [OP_W-1:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned N = 32
) ();
  import mul_div_unit_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            flush;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [N-1:0]    hi;
  logic [N-1:0]    lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit_md_iter_core.sv
// Single radix-2 step: shift-add for multiply, restoring trial subtract for divide.
module md_iter_core #(
  parameter int unsigned N = 32
) (
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   operand,
  input  logic           mode_div,
  output logic [2*N-1:0] next_acc
);

  logic [N:0] addend;
  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] trial;

  // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    addend   = '0;
    sum      = '0;
    shifted  = '0;
    trial    = '0;
    next_acc = acc;
    if (mode_div) begin
      shifted = acc[2*N-1:N-1];
      trial   = shifted - {1'b0, operand};
      if (!trial[N]) begin
        next_acc = {trial[N-1:0], acc[N-2:0], 1'b1};
      end else begin
        next_acc = {shifted[N-1:0], acc[N-2:0], 1'b0};
      end
    end else begin
      addend   = acc[0] ? {1'b0, operand} : '0;
      sum      = {1'b0, acc[2*N-1:N]} + addend;
      next_acc = {sum, acc[N-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers; one result every N+1 cycles.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input logic         clock,
  input logic         reset,
  mul_div_unit_if.slave md
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = 2 * N;

  md_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] acc, acc_nxt, core_acc;
  logic [N-1:0]  operand, operand_nxt;
  logic          is_div, is_div_nxt;
  logic          neg_res, neg_res_nxt;
  logic          neg_rem, neg_rem_nxt;
  logic          by_zero, by_zero_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          dz_q, dz_nxt;
  logic [N-1:0]  hi_q, hi_nxt;
  logic [N-1:0]  lo_q, lo_nxt;

  logic          sgn;
  logic [N-1:0]  a_mag, b_mag, quot, rem;
  logic [PW-1:0] prod;

  md_iter_core #(.N(N)) u_core (
    .acc      (acc),
    .operand  (operand),
    .mode_div (is_div),
    .next_acc (core_acc)
  );

  // Operand magnitudes and final sign fix-ups.
  assign sgn   = md_is_signed(md.op);
  assign a_mag = (sgn && md.a[N-1]) ? N'(0) - md.a : md.a;
  assign b_mag = (sgn && md.b[N-1]) ? N'(0) - md.b : md.b;
  assign prod  = neg_res ? PW'(0) - acc : acc;
  assign quot  = acc[N-1:0];
  assign rem   = acc[PW-1:N];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      by_zero <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      operand <= operand_nxt;
      is_div  <= is_div_nxt;
      neg_res <= neg_res_nxt;
      neg_rem <= neg_rem_nxt;
      by_zero <= by_zero_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      dz_q    <= dz_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    operand_nxt = operand;
    is_div_nxt  = is_div;
    neg_res_nxt = neg_res;
    neg_rem_nxt = neg_rem;
    by_zero_nxt = by_zero;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    dz_nxt      = 1'b0;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;

    case (state)
      S_IDLE: begin
        if (md.start && !md.flush) begin
          if (md_is_arith(md.op)) begin
            is_div_nxt  = md_is_div(md.op);
            neg_res_nxt = sgn & (md.a[N-1] ^ md.b[N-1]);
            neg_rem_nxt = sgn & md.a[N-1];
            by_zero_nxt = (md.b == '0);
            acc_nxt     = md_is_div(md.op) ? {N'(0), a_mag} : {N'(0), b_mag};
            operand_nxt = md_is_div(md.op) ? b_mag : a_mag;
            cnt_nxt     = CW'(N - 1);
            busy_nxt    = 1'b1;
            state_nxt   = S_CALC;
          end else if (md.op == MD_MTHI) begin
            hi_nxt = md.a;
          end else if (md.op == MD_MTLO) begin
            lo_nxt = md.a;
          end
        end
      end
      S_CALC: begin
        if (md.flush) begin
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          acc_nxt = core_acc;
          cnt_nxt = cnt - CW'(1);
          if (cnt == '0) begin
            state_nxt = S_FIX;
          end
        end
      end
      S_FIX: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
        // A flush here cancels the write-back entirely.
        if (!md.flush) begin
          done_nxt = 1'b1;
          if (is_div) begin
            lo_nxt = by_zero ? '1 : (neg_res ? N'(0) - quot : quot);
            hi_nxt = neg_rem ? N'(0) - rem : rem;
            dz_nxt = by_zero;
          end else begin
            {hi_nxt, lo_nxt} = prod;
          end
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.div_zero = dz_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a cycle-level arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned N = 32;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mul_div_unit_if #(.N(N)) md ();

  mul_div_unit #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .md    (md)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done, m_dz, p_dz;
  int          remaining;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l, output logic z);
    int          sa, sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      3'd0: begin sp = longint'(sa) * longint'(sb); {h, l} = sp; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a; z = 1'b1;
        end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = a; h = 32'd0;
        end else if (op == 3'd2) begin
          l = sa / sb; h = sa % sb;
        end else begin
          l = a / b; h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // A started arithmetic op completes N+1 edges later unless flushed first.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      remaining = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (remaining > 0) begin
        if (md.flush) begin
          remaining = 0;
          m_busy    = 1'b0;
        end else begin
          remaining--;
          if (remaining == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1; m_busy = 1'b0;
          end
        end
      end else if (md.start && !md.flush) begin
        if (md.op <= 3'd3) begin
          model_op(md.op, md.a, md.b, p_hi, p_lo, p_dz);
          remaining = N + 1;
          m_busy    = 1'b1;
        end else if (md.op == 3'd4) begin
          m_hi = md.a;
        end else if (md.op == 3'd5) begin
          m_lo = md.a;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("cycle {busy,done,dz,hi,lo}",
            80'({md.busy, md.done, md.div_zero, md.hi, md.lo}),
            80'({m_busy, m_done, m_dz, m_hi, m_lo}));
    end
  end

  // Issue at the current negedge; lat = edges from the start edge to the result edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b;
    lat = -1; bcyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      md.start = 1'b0;
      if (md.busy) bcyc++;
      if (md.done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  int lat, bcyc, ndone;

  initial begin
    reset = 1'b1;
    md.start = 1'b0; md.op = '0; md.a = '0; md.b = '0; md.flush = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_busy", 80'(md.busy), 80'(0));
    check("reset_done", 80'(md.done), 80'(0));
    check("reset_hi", 80'(md.hi), 80'(0));
    check("reset_lo", 80'(md.lo), 80'(0));
    reset = 1'b0;
    @(negedge clock);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    check("multu_latency", 80'(lat), 80'(33));
    check("multu_busy_cycles", 80'(bcyc), 80'(33));
    check("multu_hi", 80'(md.hi), 80'h0000_FFFF_FFFE);
    check("multu_lo", 80'(md.lo), 80'h1);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat, bcyc);
    check("mult_b2b_latency", 80'(lat), 80'(33));
    check("mult_neg_hi", 80'(md.hi), 80'hFFFF_FFFF);
    check("mult_neg_lo", 80'(md.lo), 80'hFFFF_FFF1);

    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, lat, bcyc);
    check("mult_min_hi", 80'(md.hi), 80'h4000_0000);
    check("mult_min_lo", 80'(md.lo), 80'h0);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
    check("div_neg_lo", 80'(md.lo), 80'hFFFF_FFFD);
    check("div_neg_hi", 80'(md.hi), 80'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd2, lat, bcyc);
    check("divu_lo", 80'(md.lo), 80'd3);
    check("divu_hi", 80'(md.hi), 80'd1);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    check("div_ovf_lo", 80'(md.lo), 80'h8000_0000);
    check("div_ovf_hi", 80'(md.hi), 80'h0);
    check("div_ovf_flag", 80'(md.div_zero), 80'(0));

    run_op(3'd3, 32'd7, 32'd0, lat, bcyc);
    check("dz_latency", 80'(lat), 80'(33));
    check("dz_lo", 80'(md.lo), 80'hFFFF_FFFF);
    check("dz_hi", 80'(md.hi), 80'd7);
    check("dz_flag", 80'(md.div_zero), 80'(1));
    @(negedge clock);
    check("dz_flag_drop", 80'(md.div_zero), 80'(0));
    check("dz_done_drop", 80'(md.done), 80'(0));

    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, lat, bcyc);
    check("dz_signed_hi", 80'(md.hi), 80'hFFFF_FFF9);
    check("dz_signed_lo", 80'(md.lo), 80'hFFFF_FFFF);
    run_op(3'd3, 32'd7, 32'd0, lat, bcyc);
    @(negedge clock);

    // Ignored start while busy, then flush mid-calculation.
    md.start = 1'b1; md.op = 3'd1; md.a = 32'd6; md.b = 32'd7;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      md.start = 1'b0;
      if (c == 5) begin md.start = 1'b1; md.op = 3'd0; md.a = 32'd9; md.b = 32'd9; end
      if (c == 10) md.flush = 1'b1;
      if (c == 11) begin
        md.flush = 1'b0;
        check("flush_busy", 80'(md.busy), 80'(0));
        check("flush_done", 80'(md.done), 80'(0));
        check("flush_hi", 80'(md.hi), 80'd7);
        check("flush_lo", 80'(md.lo), 80'hFFFF_FFFF);
      end
    end
    ndone = 0;
    repeat (40) begin
      @(negedge clock);
      if (md.done) ndone++;
    end
    check("flush_no_done", 80'(ndone), 80'(0));

    // Flush landing in the final write-back cycle.
    md.start = 1'b1; md.op = 3'd1; md.a = 32'd3; md.b = 32'd4;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clock);
      md.start = 1'b0;
    end
    md.flush = 1'b1;
    @(negedge clock);
    md.flush = 1'b0;
    check("fixflush_done", 80'(md.done), 80'(0));
    check("fixflush_busy", 80'(md.busy), 80'(0));
    check("fixflush_lo", 80'(md.lo), 80'hFFFF_FFFF);

    // Flush with start in idle drops even MTHI.
    md.start = 1'b1; md.op = 3'd4; md.a = 32'hDEAD; md.flush = 1'b1;
    @(negedge clock);
    md.start = 1'b0; md.flush = 1'b0;
    check("idleflush_hi", 80'(md.hi), 80'd7);

    md.start = 1'b1; md.op = 3'd4; md.a = 32'h1234;
    @(negedge clock);
    check("mthi_busy", 80'(md.busy), 80'(0));
    md.op = 3'd5; md.a = 32'h5678;
    @(negedge clock);
    md.start = 1'b0;
    check("mtlo_busy", 80'(md.busy), 80'(0));
    check("mthi_hi", 80'(md.hi), 80'h1234);
    check("mtlo_lo", 80'(md.lo), 80'h5678);

    // Asynchronous reset in the middle of a multiply.
    md.start = 1'b1; md.op = 3'd0; md.a = 32'd5; md.b = 32'd5;
    @(negedge clock);
    md.start = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 80'(md.busy), 80'(0));
    check("async_rst_hi", 80'(md.hi), 80'(0));
    check("async_rst_lo", 80'(md.lo), 80'(0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op(3'd1, 32'd6, 32'd7, lat, bcyc);
    check("post_rst_latency", 80'(lat), 80'(33));
    check("post_rst_lo", 80'(md.lo), 80'd42);
    check("post_rst_hi", 80'(md.hi), 80'd0);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
